// File: rtl/router_out_arbiter_if.sv
// Handshake bundle between the per-port input FIFO heads, the output FIFO
// and the round-robin output arbiter.
interface router_out_arbiter_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DW     = 8
);
  logic [NPORTS-1:0]    req;
  logic [NPORTS*DW-1:0] in_data;
  logic [NPORTS-1:0]    in_last;
  logic                 out_full;
  logic [NPORTS-1:0]    rd_en;
  logic                 out_wr;
  logic [DW-1:0]        out_data;
  logic [NPORTS-1:0]    grant;
  logic                 busy;
  logic                 len_err;

  modport master (
    output req, in_data, in_last, out_full,
    input  rd_en, out_wr, out_data, grant, busy, len_err
  );

  modport slave (
    input  req, in_data, in_last, out_full,
    output rd_en, out_wr, out_data, grant, busy, len_err
  );
endinterface

// File: rtl/router_out_arbiter.sv
// Round-robin packet arbiter: one input port owns the output until its tail
// flit (or MAXLEN flits) has been written; one idle cycle between packets.
module router_out_arbiter #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned MAXLEN = 16
) (
  input logic            clk,
  input logic            rst,
  router_out_arbiter_if.slave bus
);
  localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned CW = $clog2(MAXLEN + 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              len_err_q, len_err_d;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     cand;
  logic              found;
  logic              xfer;

  // First requester searching upward from ptr+1, wrapping modulo NPORTS.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NPORTS; k++) begin
      cand = PW'((32'(ptr_q) + k) % NPORTS);
      if (!found && bus.req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // Index of the current owner, decoded from the one-hot grant.
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (grant_q[i]) owner = PW'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    len_err_d    = 1'b0;
    xfer         = 1'b0;
    bus.rd_en    = '0;
    bus.out_wr   = 1'b0;
    bus.out_data = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = XFER;
          grant_d = NPORTS'(1) << sel;
          cnt_d   = '0;
        end
      end
      XFER: begin
        // Reset gating keeps a packet aborted by rst from losing a flit.
        xfer = bus.req[owner] && !bus.out_full && !rst;
        if (xfer) begin
          bus.rd_en[owner] = 1'b1;
          bus.out_wr       = 1'b1;
          bus.out_data     = bus.in_data[32'(owner)*DW +: DW];
          cnt_d            = cnt_q + CW'(1);
          if (bus.in_last[owner] || (cnt_q == CW'(MAXLEN - 1))) begin
            state_d   = IDLE;
            grant_d   = '0;
            ptr_d     = owner;
            len_err_d = !bus.in_last[owner];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= PW'(NPORTS - 1);
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q == XFER);
  assign bus.len_err = len_err_q;
endmodule

// File: doc/router_out_arbiter.md
ROUTER_OUT_ARBITER -- requirements
Module: router_out_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 4, number of input ports competing for one output port.
REQ-002 SHALL have parameter DW, default 8, flit data width.
REQ-003 SHALL have parameter MAXLEN, default 16, maximum flits per packet before forced release.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  NPORTS  per-port input FIFO not-empty (first-word-fall-through head valid).
REQ-007 SHALL have port in_data  input  NPORTS*DW  head flits; port i occupies bits [i*DW +: DW].
REQ-008 SHALL have port in_last  input  NPORTS  per-port tail flag of the head flit.
REQ-009 SHALL have port out_full  input  1  output FIFO full.
REQ-010 SHALL have port rd_en  output  NPORTS  per-port pop strobe, at most one bit set.
REQ-011 SHALL have port out_wr  output  1  output FIFO write strobe.
REQ-012 SHALL have port out_data  output  DW  flit written to output FIFO.
REQ-013 SHALL have port grant  output  NPORTS  registered one-hot owner of the output, zero when idle.
REQ-014 SHALL have port busy  output  1  high while in state XFER.
REQ-015 SHALL have port len_err  output  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and XFER.
REQ-017 In IDLE with any req bit set, SHALL select the first requesting port searching upward from ptr+1 modulo NPORTS, load grant one-hot with it, and enter XFER next cycle.
REQ-018 In IDLE with req all zero, SHALL remain in IDLE with grant zero.
REQ-019 In XFER with owner g, a transfer occurs in a cycle iff req[g]=1 and out_full=0.
REQ-020 On a transfer SHALL assert rd_en[g]=1 and out_wr=1 combinationally in the same cycle, with out_data=in_data[g].
REQ-021 When no transfer occurs, rd_en, out_wr SHALL be zero and out_data SHALL be zero.
REQ-022 In XFER, req[g]=0 (source underrun) or out_full=1 SHALL stall with state, grant and counter held.
REQ-023 Requests from ports other than g SHALL NOT affect grant during XFER (no preemption).
REQ-024 SHALL count transferred flits of the current packet in a counter of width clog2(MAXLEN+1), cleared on entry to XFER.
REQ-025 A transfer with in_last[g]=1 SHALL end the packet: next cycle state IDLE, grant zero, ptr<=g.
REQ-026 A transfer that is the MAXLEN-th flit with in_last[g]=0 SHALL end the packet identically and pulse len_err for the following one cycle.
REQ-027 Arbitration latency SHALL be one cycle: req seen in IDLE at cycle n -> grant at n+1 -> first flit at n+1 if not stalled.
REQ-028 Between consecutive packets SHALL be exactly one IDLE cycle (bubble), even for single-flit packets.
REQ-029 With all ports requesting continuously, grant order SHALL rotate 0,1,2,...,NPORTS-1,0.
REQ-030 busy SHALL equal (state==XFER); grant SHALL be nonzero iff busy.

Reset
REQ-031 On rst=1 at a clock edge SHALL force state IDLE, grant 0, counter 0, len_err 0, ptr NPORTS-1 (port 0 highest priority after reset).
REQ-032 While rst=1 SHALL hold rd_en, out_wr, out_data at zero regardless of req.
REQ-033 Reset asserted mid-packet SHALL abort the packet with no further flits transferred; remaining flits stay in the input FIFO.

Verification
REQ-034 Reset then req=4'b0001, 3-flit packet (in_last on 3rd), out_full=0 -> grant=0001 one cycle after req, out_wr high 3 consecutive cycles, IDLE on 4th, busy low.
REQ-035 req=4'b1111, every packet single-flit, held 8 packets -> grants 0,1,2,3,0,1,2,3 with one idle cycle between each.
REQ-036 Port 2 owner, out_full=1 for 3 cycles mid-packet -> rd_en=0, out_wr=0, grant=0100 held; resumes with next flit when out_full drops, no flit lost or duplicated.
REQ-037 Port 1 sends 16 flits without in_last (MAXLEN=16) -> 16 writes, len_err pulses one cycle, grant 0, next grant moves to port 2 if requesting.
REQ-038 rst=1 after 2 of 5 flits of port 3 -> next cycle grant 0, out_wr 0; after rst=0 with req=4'b1001, port 0 granted first.
